// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared types for the register-file write-back path.
// Holds the data/address widths, the register count, the hard-wired zero
// register, and the write-request struct used by the WB stage and the RF.
package rf_writeback_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Writes to r0 are architecturally dead and never reach the RF.
  function automatic logic is_live(input logic [ADDR_W-1:0] a);
    return a != ZERO_REG;
  endfunction

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Bundle of the write-back arbiter's handshake and bus signals.
//   pipe_*  : single-cycle write-back from the main pipeline
//   aux_*   : valid/ready results from multi-cycle units
//   rsv_*   : scoreboard reservation at multi-cycle issue
//   q_*     : scoreboard queries from the hazard unit
//   rf_*    : register-file write port
// master = the surrounding pipeline / RF side, slave = the arbiter.
interface rf_writeback_arbiter_if;
  import rf_writeback_arbiter_pkg::*;

  logic              pipe_wr_en;
  logic [ADDR_W-1:0] pipe_wr_addr;
  logic [DATA_W-1:0] pipe_wr_data;
  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] q_addr_1;
  logic [ADDR_W-1:0] q_addr_2;
  logic              q_busy_1;
  logic              q_busy_2;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    output aux_valid, aux_addr, aux_data,
    input  aux_ready,
    output rsv_en, rsv_addr, q_addr_1, q_addr_2,
    input  q_busy_1, q_busy_2,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    input  aux_valid, aux_addr, aux_data,
    output aux_ready,
    input  rsv_en, rsv_addr, q_addr_1, q_addr_2,
    output q_busy_1, q_busy_2,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO holding queued aux write-backs.
// Ports: clk, reset (sync, active-high), push/din, pop/dout (head, valid
// when !empty), full, empty. DEPTH must be a power of two >= 2; pointers
// wrap naturally. Caller must not push when full nor pop when empty.
module wb_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter.
// Merges main-pipeline write-backs (highest priority, latency 1) with
// in-order queued results from multi-cycle units, and keeps a per-register
// pending-write scoreboard for the hazard unit.
// Ports: clk, reset (sync, active-high), bus (rf_writeback_arbiter_if.slave).
// Data/address widths come from rf_writeback_arbiter_pkg; DEPTH sizes the
// aux FIFO.
// Optional macro RF_WB_BYPASS_EN: when defined, an aux result arriving with
// the FIFO empty and no live pipe write goes straight to rf_* (latency 1).
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  rf_writeback_arbiter_if.slave   bus
);

  wr_req_t           fifo_din, fifo_head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              pipe_act, aux_xfer, aux_live, bypass;
  logic              rf_we_q, rf_we_d;
  wr_req_t           rf_req_q, rf_req_d;
  logic [NREGS-1:0]  busy_q, busy_d;

  assign bus.aux_ready = !fifo_full && !reset;

  assign pipe_act = bus.pipe_wr_en && is_live(bus.pipe_wr_addr);
  assign aux_xfer = bus.aux_valid && bus.aux_ready;
  assign aux_live = aux_xfer && is_live(bus.aux_addr);

`ifdef RF_WB_BYPASS_EN
  assign bypass = aux_live && fifo_empty && !pipe_act;
`else
  assign bypass = 1'b0;
`endif

  // r0 results are accepted by the handshake but never enqueued.
  assign fifo_push     = aux_live && !bypass;
  assign fifo_din.addr = bus.aux_addr;
  assign fifo_din.data = bus.aux_data;
  // A dead (r0) pipe write leaves the slot free for a drain.
  assign fifo_pop      = !pipe_act && !fifo_empty;

  wb_sync_fifo #(.DEPTH(DEPTH), .W($bits(wr_req_t))) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rf_we_d  = 1'b0;
    rf_req_d = rf_req_q;  // addr/data hold when idle
    busy_d   = busy_q;
    if (pipe_act) begin
      rf_we_d       = 1'b1;
      rf_req_d.addr = bus.pipe_wr_addr;
      rf_req_d.data = bus.pipe_wr_data;
    end else if (fifo_pop) begin
      rf_we_d  = 1'b1;
      rf_req_d = fifo_head;
      busy_d[fifo_head.addr] = 1'b0;
    end else if (bypass) begin
      rf_we_d  = 1'b1;
      rf_req_d = fifo_din;
      busy_d[bus.aux_addr] = 1'b0;
    end
    // Reservation applied after the clear so a same-edge set wins.
    if (bus.rsv_en && is_live(bus.rsv_addr)) busy_d[bus.rsv_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q  <= 1'b0;
      rf_req_q <= '0;
      busy_q   <= '0;
    end else begin
      rf_we_q  <= rf_we_d;
      rf_req_q <= rf_req_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_req_q.addr;
  assign bus.rf_wdata = rf_req_q.data;
  assign bus.q_busy_1 = busy_q[bus.q_addr_1];
  assign bus.q_busy_2 = busy_q[bus.q_addr_2];

endmodule
